// File: rtl/systolic_seq_ctrl.sv
// Control sequencer for a DIM x DIM systolic MAC array.
// A job optionally zeroes the accumulators row by row, steps the skewed A/B
// wavefront, then drains result rows downstream under valid/ready.
// Every output is decoded from the state and counter registers only.
module systolic_seq_ctrl #(
  parameter int unsigned DIM    = 8,
  parameter int unsigned ROW_W  = $clog2(DIM),
  parameter int unsigned STEP_W = $clog2(3 * DIM - 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear_c,
  output logic              busy,
  output logic              mac_en,
  output logic              c_wr_en,
  output logic [ROW_W-1:0]  c_row,
  output logic              c_zero,
  output logic [STEP_W-1:0] feed_step,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done
);

  // The shared counter is sized for the longest phase (COMPUTE); a row index
  // always fits because 3*DIM-3 >= DIM-1.
  localparam int unsigned CntW = STEP_W;

  localparam logic [CntW-1:0] LastRow  = CntW'(DIM - 1);
  localparam logic [CntW-1:0] LastStep = CntW'(3 * DIM - 3);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StCompute,
    StDrain,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // State and shared row/step counter; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the counter restarts at 0 on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start) begin
          state_d = clear_c ? StClear : StCompute;
        end
      end
      StClear: begin
        if (cnt_q == LastRow) begin
          state_d = StCompute;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCompute: begin
        if (cnt_q == LastStep) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        // Row advances only on a handshake; holds indefinitely otherwise.
        if (out_ready) begin
          if (cnt_q == LastRow) begin
            state_d = StDone;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        // A start seen here is dropped; the first acceptable one is in IDLE.
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore output decode; feed_step and c_row read 0 outside their phases.
  always_comb begin
    busy      = 1'b0;
    mac_en    = 1'b0;
    c_wr_en   = 1'b0;
    c_zero    = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    c_row     = '0;
    feed_step = '0;
    unique case (state_q)
      StIdle: ;
      StClear: begin
        busy    = 1'b1;
        c_wr_en = 1'b1;
        c_zero  = 1'b1;
        c_row   = cnt_q[ROW_W-1:0];
      end
      StCompute: begin
        busy      = 1'b1;
        mac_en    = 1'b1;
        feed_step = cnt_q;
      end
      StDrain: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        c_row     = cnt_q[ROW_W-1:0];
      end
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
